// File: rtl/vga_scan_reader.sv
// vga_scan_reader: 640x480@60 VGA timing with scan-out from a pixel-doubled frame buffer.
// Define VGA_TEST_PATTERN_EN to add a test_mode input that replaces video with colour bars.
module vga_scan_reader #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter int unsigned FRAME_WIDTH  = 320,
    parameter int unsigned FRAME_HEIGHT = 240,
    parameter int unsigned SCALE_SHIFT  = 1,
    parameter bit          SYNC_POL     = 1'b0
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        en,
    input  logic        pix_en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic        ren,
    output logic [9:0]  x_coordinate,
    output logic [9:0]  y_coordinate,
    input  logic [23:0] rdata,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [23:0] rgb,
    output logic        frame_start
);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if ((H_ACTIVE >> SCALE_SHIFT) != FRAME_WIDTH || (V_ACTIVE >> SCALE_SHIFT) != FRAME_HEIGHT) begin : g_bad_scale
        $fatal(1, "vga_scan_reader: active area does not scale onto the frame buffer");
    end

    // Counters, stage 1 (buffer request + delayed timing) and stage 2 (pin outputs).
    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        ren;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act1;
        logic        hs1;
        logic        vs1;
        logic        fs1;
        logic [2:0]  bar1;
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } scan_t;

    localparam scan_t RST = '{hs1: ~SYNC_POL, vs1: ~SYNC_POL, hs: ~SYNC_POL, vs: ~SYNC_POL, default: '0};

    scan_t       s_q, s_d;
    logic        fs_q, fs_d;
    logic        tm, active, h_end, v_end;
    logic [23:0] pix;

`ifdef VGA_TEST_PATTERN_EN
    assign tm = test_mode;
`else
    assign tm = 1'b0;
`endif

    always_comb begin
        h_end       = s_q.h == H_LAST;
        v_end       = s_q.v == V_LAST;
        active      = (s_q.h < H_ACT) && (s_q.v < V_ACT);
        s_d         = s_q;
        s_d.h       = h_end ? '0 : s_q.h + 10'd1;
        s_d.v       = h_end ? (v_end ? '0 : s_q.v + 10'd1) : s_q.v;
        s_d.ren     = active && !tm;
        s_d.x       = active ? s_q.h >> SCALE_SHIFT : '0;
        s_d.y       = active ? s_q.v >> SCALE_SHIFT : '0;
        s_d.act1    = active;
        s_d.hs1     = (s_q.h >= HS_FIRST && s_q.h <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        s_d.vs1     = (s_q.v >= VS_FIRST && s_q.v <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        s_d.fs1     = s_q.h == '0 && s_q.v == '0;
        s_d.bar1    = s_q.h[8:6];
        // Bar colour bits fall straight out of the bar index: R=~b1, G=~b2, B=~b0.
        pix         = tm ? {{8{~s_q.bar1[1]}}, {8{~s_q.bar1[2]}}, {8{~s_q.bar1[0]}}} : rdata;
        s_d.rgb     = s_q.act1 ? pix : '0;
        s_d.de      = s_q.act1;
        s_d.hs      = s_q.hs1;
        s_d.vs      = s_q.vs1;
        fs_d        = en && pix_en && s_q.fs1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s_q  <= RST;
            fs_q <= 1'b0;
        end else begin
            if (!en || pix_en) s_q <= en ? s_d : RST;
            fs_q <= fs_d;
        end
    end

    assign ren          = s_q.ren;
    assign x_coordinate = s_q.x;
    assign y_coordinate = s_q.y;
    assign hsync        = s_q.hs;
    assign vsync        = s_q.vs;
    assign de           = s_q.de;
    assign rgb          = s_q.rgb;
    assign frame_start  = fs_q;
endmodule
